// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared defaults and access-type decode for the FIFO controller that sits in
// front of a dual-port RAM.
package fifo_ram_ctrl_pkg;

   localparam int A_LENGTH_DEF     = 3;
   localparam int D_LENGTH_DEF     = 8;
   localparam int CONFIG_DEPTH_DEF = 2 ** A_LENGTH_DEF;

   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_WR   = 2'b01,
      ACC_RD   = 2'b10,
      ACC_BOTH = 2'b11
   } acc_e;

   function automatic acc_e acc_kind(input logic wr_ok, input logic rd_ok);
      return acc_e'({rd_ok, wr_ok});
   endfunction

endpackage

// File: rtl/fifo_ram_ctrl.sv
// FIFO pointer/count controller driving an external dual-port RAM:
// port 1 writes, port 2 reads with one cycle of registered latency.
module fifo_ram_ctrl
   import fifo_ram_ctrl_pkg::*;
#(
   parameter int A_LENGTH     = A_LENGTH_DEF,
   parameter int D_LENGTH     = D_LENGTH_DEF,
   parameter int CONFIG_DEPTH = CONFIG_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_req,
   input  logic [D_LENGTH-1:0] wr_data,
   input  logic                rd_req,
   output logic [D_LENGTH-1:0] rd_data,
   output logic                rd_valid,
   output logic                full,
   output logic                empty,
   output logic [A_LENGTH:0]   level,
   output logic                wr_err,
   output logic                rd_err,
   output logic                en_port1,
   output logic                ctrl_port1,
   output logic [A_LENGTH-1:0] addr_in_port1,
   output logic [D_LENGTH-1:0] data_in_port1,
   output logic                en_port2,
   output logic                ctrl_port2,
   output logic [A_LENGTH-1:0] addr_in_port2,
   output logic [D_LENGTH-1:0] data_in_port2,
   input  logic [D_LENGTH-1:0] data_out_port2
);

   localparam int CNT_W = A_LENGTH + 1;

   logic [A_LENGTH:0] wr_ptr_q, wr_ptr_d;
   logic [A_LENGTH:0] rd_ptr_q, rd_ptr_d;
   logic [A_LENGTH:0] count_q, count_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_err_q, wr_err_d;
   logic              rd_err_q, rd_err_d;
   logic              wr_ok, rd_ok;
   acc_e              acc;

   assign full  = (count_q == CNT_W'(CONFIG_DEPTH));
   assign empty = (count_q == '0);
   assign level = count_q;

   // Full blocks the write and empty blocks the read, so the two RAM ports
   // can never address the same word in one cycle.
   assign wr_ok = wr_req && !full;
   assign rd_ok = rd_req && !empty;
   assign acc   = acc_kind(wr_ok, rd_ok);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = rd_ok;
      wr_err_d   = wr_req && full;
      rd_err_d   = rd_req && empty;
      if (wr_ok) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      case (acc)
         ACC_WR:  count_d = count_q + CNT_W'(1);
         ACC_RD:  count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         wr_err_q   <= wr_err_d;
         rd_err_q   <= rd_err_d;
      end
   end

   always_comb begin
      en_port1      = wr_ok;
      ctrl_port1    = wr_ok;
      addr_in_port1 = wr_ptr_q[A_LENGTH-1:0];
      data_in_port1 = wr_data;
      en_port2      = rd_ok;
      ctrl_port2    = 1'b0;
      addr_in_port2 = rd_ptr_q[A_LENGTH-1:0];
      data_in_port2 = '0;
   end

   // The RAM registers its read port, which lines up with rd_valid_q.
   assign rd_data  = data_out_port2;
   assign rd_valid = rd_valid_q;
   assign wr_err   = wr_err_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Scoreboard bench for fifo_ram_ctrl with a behavioural dual-port RAM beside it.
module tb_fifo_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_req, rd_req;
   logic [7:0] wr_data, rd_data;
   logic       rd_valid, full, empty, wr_err, rd_err;
   logic [3:0] level;
   logic       en_port1, ctrl_port1, en_port2, ctrl_port2;
   logic [2:0] addr_in_port1, addr_in_port2;
   logic [7:0] data_in_port1, data_in_port2, data_out_port2;

   logic [7:0] mem [8];

   typedef struct {
      logic [3:0] lvl;
      logic       werr, rerr, rdv, en1, en2, drain;
      logic [2:0] a1, a2;
      logic [7:0] d1;
   } exp_t;

   exp_t       eq[$];
   logic [7:0] dq[$];
   int         n_pass  = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   fifo_ram_ctrl dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data),
      .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty), .level(level),
      .wr_err(wr_err), .rd_err(rd_err),
      .en_port1(en_port1), .ctrl_port1(ctrl_port1),
      .addr_in_port1(addr_in_port1), .data_in_port1(data_in_port1),
      .en_port2(en_port2), .ctrl_port2(ctrl_port2),
      .addr_in_port2(addr_in_port2), .data_in_port2(data_in_port2),
      .data_out_port2(data_out_port2)
   );

   always @(posedge clk) begin
      if (en_port1 && ctrl_port1) mem[addr_in_port1] <= data_in_port1;
      if (en_port2 && !ctrl_port2) data_out_port2 <= mem[addr_in_port2];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rd_valid) begin
         if (dq.size() != 0) chk("rd_data", 32'(rd_data), 32'(dq.pop_front()));
         else chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end
      if (eq.size() != 0) begin
         e = eq.pop_front();
         chk("level", 32'(level), 32'(e.lvl));
         chk("full", 32'(full), 32'(e.lvl == 4'd8));
         chk("empty", 32'(empty), 32'(e.lvl == 4'd0));
         chk("wr_err", 32'(wr_err), 32'(e.werr));
         chk("rd_err", 32'(rd_err), 32'(e.rerr));
         chk("rd_valid", 32'(rd_valid), 32'(e.rdv));
         chk("en_port1", 32'(en_port1), 32'(e.en1));
         chk("ctrl_port1", 32'(ctrl_port1), 32'(e.en1));
         chk("en_port2", 32'(en_port2), 32'(e.en2));
         chk("ctrl_port2", 32'(ctrl_port2), 32'd0);
         chk("data_in_port2", 32'(data_in_port2), 32'd0);
         if (e.en1) begin
            chk("addr_in_port1", 32'(addr_in_port1), 32'(e.a1));
            chk("data_in_port1", 32'(data_in_port1), 32'(e.d1));
         end
         if (e.en2) chk("addr_in_port2", 32'(addr_in_port2), 32'(e.a2));
         if (e.drain) chk("rd_queue_left", 32'(dq.size()), 32'd0);
      end
   end

   // One cycle: drive inputs just after the edge and queue what the monitor
   // should see at the following falling edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic push, input logic [7:0] rdexp,
                      input int lvl, input logic werr, input logic rerr, input logic rdv,
                      input logic en1, input int a1, input logic en2, input int a2,
                      input logic rst = 1'b1, input logic drain = 1'b0);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n   = rst;
      wr_req  = w;
      wr_data = d;
      rd_req  = r;
      e.lvl = 4'(lvl); e.werr = werr; e.rerr = rerr; e.rdv = rdv;
      e.en1 = en1; e.a1 = 3'(a1); e.d1 = d;
      e.en2 = en2; e.a2 = 3'(a2); e.drain = drain;
      eq.push_back(e);
      if (push) dq.push_back(rdexp);
   endtask

   initial begin
      rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
      repeat (2) @(posedge clk);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      // fill: 0x11..0x18 at addresses 0..7
      for (int i = 0; i < 8; i++)
         cyc(1, 8'(8'h11 + i), 0, 0, 8'h00, i, 0, 0, 0, 1, i, 0, 0);
      // write while full is rejected; wr_err pulses for exactly one cycle
      cyc(1, 8'h99, 0, 0, 8'h00, 8, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 8'h00, 8, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 8'h00, 8, 0, 0, 0, 0, 0, 0, 0);
      // drain 8 back-to-back
      for (int i = 0; i < 8; i++)
         cyc(0, 8'h00, 1, 1, 8'(8'h11 + i), 8 - i, 0, 0, (i > 0), 0, 0, 1, i);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
      // simultaneous read+write on empty: write wins, read rejected
      cyc(1, 8'h42, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 8'h00, 1, 1, 8'h42, 1, 0, 1, 0, 0, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
      // bring to level 4 with wr_ptr at 6
      for (int j = 0; j < 5; j++)
         cyc(1, 8'(8'h51 + j), 0, 0, 8'h00, j, 0, 0, 0, 1, 1 + j, 0, 0);
      cyc(0, 8'h00, 1, 1, 8'h51, 5, 0, 0, 0, 0, 0, 1, 1);
      // streaming read+write across the address wrap
      for (int k = 0; k < 4; k++)
         cyc(1, 8'(8'h61 + k), 1, 1, 8'(8'h52 + k), 4, 0, 0, 1, 1, (6 + k) % 8, 1, 2 + k);
      for (int k = 0; k < 4; k++)
         cyc(0, 8'h00, 1, 1, 8'(8'h61 + k), 4 - k, 0, 0, 1, 0, 0, 1, (6 + k) % 8);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
      // accepted read followed by reset: no rd_valid, contents discarded
      cyc(1, 8'h77, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 0, 0);
      cyc(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 2);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 The block SHALL take three parameters, each with the value of the matching shared macro as its default:
  A_LENGTH, 3, address width.
  D_LENGTH, 8, data width.
  CONFIG_DEPTH, 8, word count, equal to 2**A_LENGTH.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have the following ports:
  clk  in  1  sole clock; also drives both RAM port clocks at the enclosing top.
  rst_n  in  1  asynchronous active-low reset.
  wr_req  in  1  write request.
  wr_data  in  D_LENGTH  write word.
  rd_req  in  1  read request.
  rd_data  out  D_LENGTH  read word, valid when rd_valid=1.
  rd_valid  out  1  read-data strobe.
  full  out  1  FIFO holds CONFIG_DEPTH words.
  empty  out  1  FIFO holds 0 words.
  level  out  A_LENGTH+1  current word count.
  wr_err  out  1  one-cycle pulse: a write was rejected.
  rd_err  out  1  one-cycle pulse: a read was rejected.
  en_port1, ctrl_port1  out  1 each  RAM write-port enable and write select.
  addr_in_port1  out  A_LENGTH  RAM write address.
  data_in_port1  out  D_LENGTH  RAM write data.
  en_port2, ctrl_port2  out  1 each  RAM read-port enable and read/write select.
  addr_in_port2  out  A_LENGTH  RAM read address.
  data_in_port2  out  D_LENGTH  RAM read-port data; tied to 0.
  data_out_port2  in  D_LENGTH  RAM read-port data, registered by the RAM.

Function
REQ-004 The block SHALL keep wr_ptr, rd_ptr and count as A_LENGTH+1-bit registers; each pointer addresses the RAM with its low A_LENGTH bits and wraps naturally past CONFIG_DEPTH-1.
REQ-005 The full and empty outputs SHALL be combinational decodes of count: full = (count==CONFIG_DEPTH); empty = (count==0); level = count.
REQ-006 A write SHALL be accepted when wr_req && !full; in that same cycle the block drives en_port1=1, ctrl_port1=1, addr_in_port1=wr_ptr low bits and data_in_port1=wr_data (combinational), and wr_ptr increments at the edge.
REQ-007 A read SHALL be accepted when rd_req && !empty; in that same cycle the block drives en_port2=1, ctrl_port2=0 and addr_in_port2=rd_ptr low bits, and rd_ptr increments at the edge.
REQ-008 rd_valid SHALL be a register set one cycle after an accepted read, and rd_data SHALL pass data_out_port2 through; read latency is 1 cycle.
REQ-009 When neither access is accepted, en_port1 and en_port2 SHALL be 0; ctrl_port2 and data_in_port2 SHALL always be 0.
REQ-010 count SHALL update per cycle as:
  write only: +1.
  read only: -1.
  both or neither accepted: unchanged.
REQ-011 When full, a write SHALL be rejected even if a read is accepted in the same cycle; the next cycle has wr_err=1.
REQ-012 When empty, a read SHALL be rejected even if a write is accepted in the same cycle; the next cycle has rd_err=1.
REQ-013 Rejected requests SHALL change no pointer, count or RAM content.
REQ-014 Read and write SHALL never target the same RAM address in one cycle; the low pointer bits are equal only when full or empty, and REQ-011/012 block one side.
REQ-015 Back-to-back accepted reads SHALL stream at one word per cycle with rd_valid held high.

Reset
REQ-016 While rst_n=0, asynchronously: wr_ptr, rd_ptr, count = 0; rd_valid, wr_err, rd_err = 0; hence empty=1, full=0, level=0.
REQ-017 Reset during operation SHALL discard contents; an accepted read in the cycle before reset SHALL NOT produce rd_valid.
REQ-018 Reset SHALL NOT clear RAM contents; stale words are unreachable through the pointers.
REQ-019 Deassertion SHALL be used synchronously to clk by the enclosing top.

Structure
REQ-020 The macros a_length, d_length and config_depth SHALL live in the shared parameter header para.h; the block defines no local width constants.
REQ-021 The block SHALL contain no sub-module; the dual-port RAM is instantiated beside it in the enclosing top, with port 1 as write-only and port 2 as read-only.

Verification
REQ-022 Reset then write 0x11..0x18 (8 writes) -> full=1 after the 8th edge, level=8, en_port1 pulses 8 times at addresses 0..7.
REQ-023 From full, wr_req with 0x99 -> wr_err=1 for one cycle, level stays 8, RAM word 0 unchanged.
REQ-024 Read 8 consecutive cycles -> rd_valid high cycles 2..9, rd_data=0x11..0x18 in order, empty=1 after the 8th read.
REQ-025 From empty: rd_req+wr_req(0x42) together -> rd_err=1 and level=1; next read returns 0x42.
REQ-026 level=4 at wr_ptr=6: simultaneous read+write for 4 cycles -> level constant 4, wr addresses 6,7,0,1 (wrap), data order preserved.
REQ-027 Read accepted, rst_n low for the following cycle -> rd_valid=0, empty=1, level=0 after reset.
